// File: rtl/alu_vector_recorder_if.sv
// Capture-side and nibble-stream-side signals of the ALU vector recorder.
// The slave modport is the recorder's view; master is the producer/sink's view.
interface alu_vector_recorder_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ALUControl;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_nibble;
   logic        out_last;

   modport slave (
      input  in_valid, ALUControl, A, B, y, out_ready,
      output in_ready, out_valid, out_nibble, out_last
   );

   modport master (
      output in_valid, ALUControl, A, B, y, out_ready,
      input  in_ready, out_valid, out_nibble, out_last
   );
endinterface

// File: rtl/alu_vector_recorder.sv
// Packs ALU transactions into 100-bit vectors, queues them, and streams each as 25 hex nibbles MSB-first.
// Latency: 2 cycles capture-to-first-nibble when idle; in_ready drops on a full FIFO, out_ready stalls the stream.
module alu_vector_recorder #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   alu_vector_recorder_if.slave bus,
   output logic                 overflow,
   output logic [CNT_W-1:0]     vec_count
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   logic [99:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic [99:0]   wdat;

   state_t        state;
   state_t        state_n;
   logic [99:0]   shreg;
   logic [4:0]    digit;
   logic          load;
   logic          shift;
   logic          inc_cnt;
   logic          last_digit;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign wdat  = {2'b00, bus.ALUControl, bus.A, bus.B, bus.y};

   // Registered full only: a pop this cycle does not open a slot for this cycle's push.
   assign bus.in_ready = !full;
   assign push         = bus.in_valid && !full && !clear;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign last_digit = (digit == 5'd24);

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      load    = 1'b0;
      shift   = 1'b0;
      inc_cnt = 1'b0;
      if (clear) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  pop     = 1'b1;
                  load    = 1'b1;
                  state_n = SEND;
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  if (!last_digit) begin
                     shift = 1'b1;
                  end else begin
                     inc_cnt = 1'b1;
                     // Chain straight into the next queued vector to avoid a bubble.
                     if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                     end else begin
                        state_n = IDLE;
                     end
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         digit     <= '0;
         vec_count <= '0;
         overflow  <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            shreg <= mem[rd_ptr];
            digit <= '0;
         end else if (shift) begin
            shreg <= {shreg[95:0], 4'h0};
            digit <= digit + 5'd1;
         end
         if (inc_cnt) vec_count <= vec_count + 1'b1;
         if (clear)                          overflow <= 1'b0;
         else if (bus.in_valid && full)      overflow <= 1'b1;
      end
   end

   assign bus.out_valid  = (state == SEND);
   assign bus.out_nibble = (state == SEND) ? shreg[99:96] : 4'h0;
   assign bus.out_last   = (state == SEND) && last_digit;
endmodule

// File: tb/tb_alu_vector_recorder.sv
// Directed bench for alu_vector_recorder: hand-computed vectors checked with immediate assertions.
module tb_alu_vector_recorder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        overflow;
   logic [15:0] vec_count;
   int          checks = 0;
   int          fails = 0;

   alu_vector_recorder_if bus ();

   alu_vector_recorder #(.DEPTH(16), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .bus       (bus.slave),
      .overflow  (overflow),
      .vec_count (vec_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [99:0] v);
      bus.in_valid   = 1'b1;
      bus.ALUControl = v[97:96];
      bus.A          = v[95:64];
      bus.B          = v[63:32];
      bus.y          = v[31:0];
      step();
      bus.in_valid   = 1'b0;
   endtask

   function automatic logic [99:0] mk(input int k);
      logic [31:0] kk;
      kk = k;
      return {2'b00, kk[1:0], 32'hA000_0000 + kk, ~kk, kk * 3};
   endfunction

   // Receive one vector; with toggle, out_ready runs 0,1,0,1... from the first valid cycle.
   task automatic rx(input int budget, input bit toggle, output logic [99:0] word, output int cycles);
      int         n = 0;
      int         waited = 0;
      bit         started = 0;
      bit         holding = 0;
      bit         stable_ok = 1;
      bit         last_ok = 1;
      logic [3:0] held = '0;
      word   = '0;
      cycles = 0;
      while (n < 25 && waited < budget) begin
         bus.out_ready = toggle ? (cycles % 2 == 1) : 1'b1;
         if (bus.out_valid) begin
            started = 1;
            if (holding && bus.out_nibble !== held) stable_ok = 0;
            if (bus.out_ready) begin
               if (bus.out_last !== (n == 24)) last_ok = 0;
               word    = {word[95:0], bus.out_nibble};
               n++;
               holding = 0;
            end else begin
               held    = bus.out_nibble;
               holding = 1;
            end
         end
         step();
         waited++;
         if (started) cycles++;
      end
      check("rx_nibble_count", n, 25);
      check("rx_out_last_position", last_ok, 1);
      check("rx_hold_stable", stable_ok, 1);
   endtask

   logic [99:0] word;
   logic [99:0] words [3];
   int          cyc;
   bit          ok;

   initial begin
      bus.in_valid   = 1'b0;
      bus.ALUControl = '0;
      bus.A          = '0;
      bus.B          = '0;
      bus.y          = '0;
      bus.out_ready  = 1'b1;
      #12;
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_nibble", bus.out_nibble, 0);
      check("reset_out_last", bus.out_last, 0);
      check("reset_overflow", overflow, 0);
      check("reset_vec_count", vec_count, 0);
      rst_n = 1'b1;
      step();

      // Single vector, latency and content
      push({2'b00, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008});
      check("lat_not_yet_valid", bus.out_valid, 0);
      step();
      check("lat_valid_after_pop", bus.out_valid, 1);
      check("lat_first_nibble", bus.out_nibble, 0);
      rx(50, 0, word, cyc);
      check("t1_word", word, 100'h0_0000_0005_0000_0003_0000_0008);
      check("t1_cycles", cyc, 25);
      check("t1_vec_count", vec_count, 1);
      check("t1_idle_after", bus.out_valid, 0);

      // Opcode field in the top nibble
      push({2'b00, 2'b11, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_000F});
      step();
      check("t2_first_nibble", bus.out_nibble, 4'h3);
      rx(50, 0, word, cyc);
      check("t2_word", word, 100'h3_FFFF_FFFF_0000_000F_0000_000F);
      check("t2_vec_count", vec_count, 2);

      // Backpressure toggling every cycle
      bus.out_ready = 1'b0;
      push({2'b00, 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C});
      rx(100, 1, word, cyc);
      check("t3_word", word, 100'h2_1234_5678_9ABC_DEF0_0F1E_2D3C);
      check("t3_cycles", cyc, 50);
      check("t3_vec_count", vec_count, 3);

      // Overflow: one vector parked in the shift register, then DEPTH+1 pushes
      bus.out_ready = 1'b0;
      push(mk(100));
      step();
      step();
      check("t4_parked_valid", bus.out_valid, 1);
      ok = 1;
      for (int k = 0; k < 17; k++) begin
         if (bus.in_ready !== (k < 16)) ok = 0;
         push(mk(k));
      end
      check("t4_in_ready_pattern", ok, 1);
      check("t4_in_ready_full", bus.in_ready, 0);
      check("t4_overflow_set", overflow, 1);
      rx(60, 0, word, cyc);
      check("t4_parked_word", word, mk(100));
      for (int k = 0; k < 16; k++) begin
         rx(60, 0, word, cyc);
         check($sformatf("t4_fifo_order_%0d", k), word, mk(k));
      end
      step();
      step();
      check("t4_drained_idle", bus.out_valid, 0);
      check("t4_vec_count", vec_count, 20);
      check("t4_overflow_sticky", overflow, 1);

      // Back-to-back: 75 consecutive nibbles
      bus.out_ready = 1'b0;
      for (int k = 20; k < 23; k++) push(mk(k));
      step();
      step();
      ok = 1;
      for (int i = 0; i < 3; i++) words[i] = '0;
      for (int i = 0; i < 75; i++) begin
         bus.out_ready = 1'b1;
         if (bus.out_valid !== 1'b1) ok = 0;
         if (bus.out_last !== (i % 25 == 24)) ok = 0;
         words[i/25] = {words[i/25][95:0], bus.out_nibble};
         step();
      end
      check("t5_no_bubble_last", ok, 1);
      check("t5_word0", words[0], mk(20));
      check("t5_word1", words[1], mk(21));
      check("t5_word2", words[2], mk(22));
      check("t5_vec_count", vec_count, 23);
      check("t5_idle_after", bus.out_valid, 0);

      // clear mid-vector with two queued
      bus.out_ready = 1'b0;
      for (int k = 30; k < 33; k++) push(mk(k));
      step();
      check("t6_overflow_before", overflow, 1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("t6_still_sending", bus.out_valid, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t6_out_valid_cleared", bus.out_valid, 0);
      check("t6_overflow_cleared", overflow, 0);
      check("t6_vec_count_kept", vec_count, 23);
      check("t6_in_ready", bus.in_ready, 1);
      ok = 1;
      for (int i = 0; i < 30; i++) begin
         if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) ok = 0;
         step();
      end
      check("t6_no_output_after_clear", ok, 1);
      push(mk(33));
      rx(60, 0, word, cyc);
      check("t6_new_word", word, mk(33));
      check("t6_vec_count_new", vec_count, 24);

      // Asynchronous reset mid-emission
      push(mk(40));
      for (int i = 0; i < 6; i++) step();
      check("t7_sending", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t7_rst_out_valid", bus.out_valid, 0);
      check("t7_rst_out_nibble", bus.out_nibble, 0);
      check("t7_rst_vec_count", vec_count, 0);
      check("t7_rst_in_ready", bus.in_ready, 1);
      rst_n = 1'b1;
      step();
      step();
      check("t7_no_resume", bus.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
